// File: rtl/fifo_stream_reader_if.sv
// fifo_stream_reader_if: FIFO read port plus valid/ready byte stream.
// master is the reader side, slave is the FIFO/downstream side.
interface fifo_stream_reader_if;
  logic       fifo_empty;
  logic [7:0] fifo_data;
  logic       fifo_read_enb;
  logic       m_valid;
  logic [7:0] m_data;
  logic       m_last;
  logic       m_ready;
  modport master (
    input  fifo_empty, fifo_data, m_ready,
    output fifo_read_enb, m_valid, m_data, m_last
  );
  modport slave (
    output fifo_empty, fifo_data, m_ready,
    input  fifo_read_enb, m_valid, m_data, m_last
  );
endinterface

// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader: reads a synchronous FIFO into a 2-entry skid buffer and
// presents bytes on a valid/ready stream with packet-end marking.
module fifo_stream_reader #(
  parameter int PKT_LEN = 4,
  parameter int CNT_W   = 16
) (
  input  logic                 clock,
  input  logic                 resetn,
  input  logic                 en,
  fifo_stream_reader_if.master bus,
  output logic [CNT_W-1:0]     byte_count
);
  localparam logic [7:0] LAST_IDX = 8'(PKT_LEN - 1);
  logic [1:0]       occ_q, occ_d;
  logic             inflight_q, inflight_d;
  logic [7:0]       pkt_idx_q, pkt_idx_d;
  logic [7:0]       d0_q, d0_d, d1_q, d1_d;
  logic             l0_q, l0_d, l1_q, l1_d;
  logic [CNT_W-1:0] byte_count_q, byte_count_d;
  logic             pop, cap, cap_last, rd_en;
  logic [1:0]       tail;
  always_comb begin
    pop          = (occ_q != 2'd0) & bus.m_ready;
    cap          = inflight_q;
    cap_last     = pkt_idx_q == LAST_IDX;
    // credit: buffered plus in-flight bytes, net of this cycle's pop, stay under 2
    rd_en        = en & ~bus.fifo_empty & ((occ_q + {1'b0, inflight_q} - {1'b0, pop}) < 2'd2);
    inflight_d   = rd_en & ~bus.fifo_empty;
    tail         = occ_q - {1'b0, pop};
    d0_d         = pop ? d1_q : d0_q;
    l0_d         = pop ? l1_q : l0_q;
    d1_d         = d1_q;
    l1_d         = l1_q;
    if (cap && tail == 2'd0) begin
      d0_d = bus.fifo_data;
      l0_d = cap_last;
    end
    if (cap && tail == 2'd1) begin
      d1_d = bus.fifo_data;
      l1_d = cap_last;
    end
    occ_d        = occ_q + {1'b0, cap} - {1'b0, pop};
    pkt_idx_d    = cap ? (cap_last ? 8'd0 : pkt_idx_q + 8'd1) : pkt_idx_q;
    byte_count_d = byte_count_q + CNT_W'(pop);
  end
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      occ_q        <= 2'd0;
      inflight_q   <= 1'b0;
      pkt_idx_q    <= 8'd0;
      d0_q         <= 8'd0;
      d1_q         <= 8'd0;
      l0_q         <= 1'b0;
      l1_q         <= 1'b0;
      byte_count_q <= '0;
    end else begin
      occ_q        <= occ_d;
      inflight_q   <= inflight_d;
      pkt_idx_q    <= pkt_idx_d;
      d0_q         <= d0_d;
      d1_q         <= d1_d;
      l0_q         <= l0_d;
      l1_q         <= l1_d;
      byte_count_q <= byte_count_d;
    end
  end
  assign bus.fifo_read_enb = rd_en;
  assign bus.m_valid       = occ_q != 2'd0;
  assign bus.m_data        = d0_q;
  assign bus.m_last        = l0_q;
  assign byte_count        = byte_count_q;
  a_no_overflow: assert property (@(posedge clock) disable iff (!resetn)
    !(occ_q == 2'd2 && inflight_q && !pop));
endmodule

// File: tb/tb_fifo_stream_reader.sv
// tb_fifo_stream_reader: directed checks on a PKT_LEN=4 instance and a random
// stress run on a PKT_LEN=3 instance, each fed by a behavioural 4-deep FIFO.
module tb_fifo_stream_reader;
  logic clock = 1'b0;
  logic resetn = 1'b0;
  always #5 clock = ~clock;
  logic [1:0]       en, m_ready, wr_en, mv, ml, rd, full;
  logic [1:0][7:0]  wr_data, md;
  logic [1:0][15:0] bc;
  logic [1:0][2:0]  fcnt;
  logic [1:0][31:0] reads;
  int total = 0;
  int bad = 0;
  for (genvar g = 0; g < 2; g++) begin : gen
    fifo_stream_reader_if bus();
    logic [7:0]  mem [4];
    logic [2:0]  cnt;
    logic [1:0]  wp, rp;
    logic [7:0]  dout;
    logic [31:0] nrd;
    fifo_stream_reader #(.PKT_LEN((g == 0) ? 4 : 3), .CNT_W(16)) dut (
      .clock(clock), .resetn(resetn), .en(en[g]), .bus(bus), .byte_count(bc[g])
    );
    always @(posedge clock or negedge resetn) begin
      if (!resetn) begin
        cnt  <= 3'd0;
        wp   <= 2'd0;
        rp   <= 2'd0;
        dout <= 8'd0;
        nrd  <= 32'd0;
      end else begin
        if (wr_en[g] && cnt != 3'd4) begin
          mem[wp] <= wr_data[g];
          wp      <= wp + 2'd1;
        end
        if (bus.fifo_read_enb && cnt != 3'd0) begin
          dout <= mem[rp];
          rp   <= rp + 2'd1;
          nrd  <= nrd + 32'd1;
        end
        cnt <= cnt + 3'(wr_en[g] && cnt != 3'd4) - 3'(bus.fifo_read_enb && cnt != 3'd0);
      end
    end
    assign bus.fifo_empty = cnt == 3'd0;
    assign bus.fifo_data  = dout;
    assign bus.m_ready    = m_ready[g];
    assign mv[g]    = bus.m_valid;
    assign md[g]    = bus.m_data;
    assign ml[g]    = bus.m_last;
    assign rd[g]    = bus.fifo_read_enb;
    assign full[g]  = cnt == 3'd4;
    assign fcnt[g]  = cnt;
    assign reads[g] = nrd;
  end
  task automatic step();
    @(negedge clock);
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic push0(input logic [7:0] b);
    wr_en[0]   = 1'b1;
    wr_data[0] = b;
    step();
    wr_en[0]   = 1'b0;
  endtask
  task automatic expect_stream(input logic [7:0] e0, e1, e2, e3, input int last_at, input string tag);
    logic [7:0] e [4];
    int got;
    e   = '{e0, e1, e2, e3};
    got = 0;
    for (int c = 0; c < 20 && got < 4; c++) begin
      if (mv[0]) begin
        chk({tag, "_data"}, 32'(md[0]), 32'(e[got]));
        chk({tag, "_last"}, 32'(ml[0]), 32'(got == last_at));
        got++;
      end
      step();
    end
    chk({tag, "_count"}, 32'(got), 32'd4);
  endtask
  initial begin
    logic [7:0]  pat [4];
    logic [7:0]  q [$];
    logic [31:0] base;
    int wrote, acc;
    pat = '{8'h24, 8'h81, 8'h09, 8'h63};
    en = '0; m_ready = '0; wr_en = '0; wr_data = '0;
    en[0] = 1'b1;
    repeat (2) step();
    chk("rst_rd", 32'(rd[0]), 32'd0);
    chk("rst_valid", 32'(mv[0]), 32'd0);
    chk("rst_data", 32'(md[0]), 32'd0);
    chk("rst_last", 32'(ml[0]), 32'd0);
    chk("rst_bc", 32'(bc[0]), 32'd0);
    resetn = 1'b1;
    repeat (3) step();
    chk("idle_reads", reads[0], 32'd0);
    chk("idle_rd", 32'(rd[0]), 32'd0);
    en[0] = 1'b0;
    m_ready[0] = 1'b1;
    for (int i = 0; i < 4; i++) push0(pat[i]);
    en[0] = 1'b1;
    step();
    chk("drain_lat", 32'(mv[0]), 32'd0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("drain_valid", 32'(mv[0]), 32'd1);
      chk("drain_data", 32'(md[0]), 32'(pat[i]));
      chk("drain_last", 32'(ml[0]), 32'(i == 3));
      chk("drain_bc", 32'(bc[0]), 32'(i));
    end
    step();
    chk("drain_end_valid", 32'(mv[0]), 32'd0);
    chk("drain_end_bc", 32'(bc[0]), 32'd4);
    en[0] = 1'b0;
    m_ready[0] = 1'b0;
    for (int i = 0; i < 4; i++) push0(pat[i]);
    base = reads[0];
    en[0] = 1'b1;
    repeat (6) step();
    chk("bp_reads", reads[0] - base, 32'd2);
    chk("bp_valid", 32'(mv[0]), 32'd1);
    chk("bp_data", 32'(md[0]), 32'h24);
    chk("bp_full", 32'(full[0]), 32'd0);
    chk("bp_left", 32'(fcnt[0]), 32'd2);
    m_ready[0] = 1'b1;
    expect_stream(pat[0], pat[1], pat[2], pat[3], 3, "bp");
    chk("bp_bc", 32'(bc[0]), 32'd8);
    repeat (5) begin
      step();
      chk("empty_valid", 32'(mv[0]), 32'd0);
    end
    chk("empty_bc", 32'(bc[0]), 32'd8);
    push0(8'h0d);
    chk("one_w", 32'(mv[0]), 32'd0);
    step();
    chk("one_e0", 32'(mv[0]), 32'd0);
    step();
    chk("one_valid", 32'(mv[0]), 32'd1);
    chk("one_data", 32'(md[0]), 32'h0d);
    chk("one_last", 32'(ml[0]), 32'd0);
    step();
    chk("one_bc", 32'(bc[0]), 32'd9);
    en[0] = 1'b0;
    push0(8'ha1); push0(8'ha2); push0(8'ha3);
    base = reads[0];
    en[0] = 1'b1;
    step();
    en[0] = 1'b0;
    step();
    chk("gate_valid", 32'(mv[0]), 32'd1);
    chk("gate_data", 32'(md[0]), 32'ha1);
    repeat (3) step();
    chk("gate_reads", reads[0] - base, 32'd1);
    chk("gate_drained", 32'(mv[0]), 32'd0);
    chk("gate_bc", 32'(bc[0]), 32'd10);
    chk("gate_left", 32'(fcnt[0]), 32'd2);
    push0(8'ha4);
    en[0] = 1'b1;
    step();
    step();
    chk("mid_head", 32'(md[0]), 32'ha2);
    step();
    m_ready[0] = 1'b0;
    step();
    chk("mid_valid", 32'(mv[0]), 32'd1);
    chk("mid_data", 32'(md[0]), 32'ha3);
    chk("mid_last", 32'(ml[0]), 32'd1);
    chk("mid_bc", 32'(bc[0]), 32'd11);
    #2 resetn = 1'b0;
    #1;
    chk("arst_valid", 32'(mv[0]), 32'd0);
    chk("arst_data", 32'(md[0]), 32'd0);
    chk("arst_last", 32'(ml[0]), 32'd0);
    chk("arst_bc", 32'(bc[0]), 32'd0);
    chk("arst_rd", 32'(rd[0]), 32'd0);
    en[0] = 1'b0;
    step();
    resetn = 1'b1;
    push0(8'h5a); push0(8'h3c); push0(8'he7); push0(8'h42);
    m_ready[0] = 1'b1;
    en[0] = 1'b1;
    expect_stream(8'h5a, 8'h3c, 8'he7, 8'h42, 3, "rst");
    en[0] = 1'b0;
    en[1] = 1'b1;
    wrote = 0;
    acc = 0;
    for (int c = 0; c < 20000 && acc < 1000; c++) begin
      chk("st_bc", 32'(bc[1]), 32'(acc[15:0]));
      chk("st_credit", 32'((reads[1] - 32'(acc)) <= 32'd2), 32'd1);
      m_ready[1] = 1'($urandom_range(0, 1));
      wr_en[1] = 1'b0;
      if (wrote < 1000 && !full[1] && $urandom_range(0, 3) != 0) begin
        wr_en[1]   = 1'b1;
        wr_data[1] = 8'($urandom);
        q.push_back(wr_data[1]);
        wrote++;
      end
      if (mv[1] && m_ready[1]) begin
        if (q.size() == 0) begin
          chk("st_spurious", 32'(md[1]), 32'hffff_ffff);
        end else begin
          chk("st_data", 32'(md[1]), 32'(q.pop_front()));
        end
        chk("st_last", 32'(ml[1]), 32'(acc % 3 == 2));
        acc++;
      end
      step();
    end
    wr_en[1] = 1'b0;
    chk("st_done", 32'(acc), 32'd1000);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fifo_stream_reader.md
# fifo_stream_reader

Read-side consumer for the 4-deep, 8-bit synchronous `fifo`. It drives the FIFO's `read_enb`, captures `data_out`, and presents the bytes on a valid/ready output stream. A 2-entry skid buffer gives full throughput under backpressure, and `m_last` marks packet boundaries. It sits between the FIFO and any downstream byte consumer, and shares the FIFO's `clock` and `resetn`.

## Interface
Parameters:
- `PKT_LEN`, default 4: bytes per packet; `m_last` marks every `PKT_LEN`-th byte. Legal range 1..255.
- `CNT_W`, default 16: width of `byte_count`.

Ports:
- `clock` — input, 1 — single clock, rising edge.
- `resetn` — input, 1 — asynchronous, active-low reset.
- `en` — input, 1 — allows new FIFO reads; reads already in flight always complete.
- `fifo_empty` — input, 1 — FIFO `empty` flag.
- `fifo_data` — input, 8 — FIFO `data_out`.
- `fifo_read_enb` — output, 1 — FIFO `read_enb`.
- `m_valid` — output, 1 — output byte valid.
- `m_data` — output, 8 — output byte.
- `m_last` — output, 1 — current byte ends a packet.
- `m_ready` — input, 1 — downstream accepts the byte.
- `byte_count` — output, `CNT_W` — total bytes accepted downstream; wraps modulo 2^`CNT_W`.

## Operation
- FIFO read contract (fixed):
  - A read is issued at edge E when `fifo_read_enb`=1 and `fifo_empty`=0 at E.
  - `fifo_data` holds that byte after E and is captured at edge E+1.
  - `fifo_read_enb` while `fifo_empty`=1 has no effect and no read is counted.
- State:
  - `occ` ∈ {0,1,2}: skid buffer occupancy.
  - `inflight` (1 bit): a read was issued at the previous edge.
  - `pkt_idx`: 0..`PKT_LEN`-1.
  - 2 entries of {data[7:0], last}, FIFO-ordered, head at entry 0.
- Definitions:
  - `pop` = `m_valid` & `m_ready`.
  - `fifo_read_enb` = `en` & ~`fifo_empty` & (`occ` + `inflight` − `pop` < 2). This term is combinational from registered state, `en`, `fifo_empty` and `m_ready`.
  - `inflight` next = `fifo_read_enb` & ~`fifo_empty`.
- Capture (when `inflight`=1):
  - Write `fifo_data` into the tail entry.
  - The entry's `last` = (`pkt_idx` == `PKT_LEN`−1).
  - `pkt_idx` advances, wrapping to 0 after `PKT_LEN`−1.
- Outputs:
  - `m_valid` = (`occ` != 0).
  - `m_data` and `m_last` come from the head entry.
- Pop: the head shifts out, entry 1 moves to entry 0, and `byte_count` increments.
- Capture and pop in the same cycle: `occ` is unchanged, and the new byte lands behind the remaining entry (or at the head if `occ` was 1).
- Occupancy states and transitions:
  - EMPTY(0) → ONE on capture without pop.
  - ONE → TWO on capture without pop.
  - ONE → EMPTY on pop without capture.
  - TWO → ONE on pop without capture.
  - TWO with capture and no pop cannot occur; the credit rule guarantees this. Verify it with an assertion.
- `en`=0 stops new reads only. An in-flight byte is still captured, and buffered bytes still drain.
- `PKT_LEN`=1: every byte has `m_last`=1.

## Timing
- Reset (asynchronous, while `resetn`=0):
  - `fifo_read_enb`=0.
  - `m_valid`=0, `m_data`=8'h00, `m_last`=0.
  - `byte_count`=0, `occ`=0, `inflight`=0, `pkt_idx`=0.
  - Reset mid-operation discards buffered and in-flight bytes (the FIFO is reset by the same `resetn`).
- Latency: from a read issued at edge E, `m_valid` rises after edge E+1. The first byte appears 2 edges after `fifo_empty` falls, given `en`=1 and an empty buffer.
- Throughput: 1 byte/cycle sustained while `m_ready`=1 and the FIFO is non-empty.
- Backpressure:
  - While `m_valid`=1 and `m_ready`=0, `m_data`/`m_last` hold stable and `m_valid` does not drop.
  - At most 2 bytes are buffered plus in flight at any time.
  - Reads stop after `occ`+`inflight` reaches 2 without a pop.
- No combinational path from `fifo_data` to any output. `m_ready` and `fifo_empty` reach `fifo_read_enb` combinationally.

## Test plan
- Reset:
  - Hold `resetn`=0 with the FIFO holding data → `fifo_read_enb`=0, `m_valid`=0, `byte_count`=0.
  - After release, with the FIFO empty → no reads are issued.
- Drain at full rate:
  - FIFO loaded with 0x24, 0x81, 0x09, 0x63; `m_ready`=1, `PKT_LEN`=4.
  - Output must be 0x24, 0x81, 0x09, 0x63 on consecutive cycles, starting 2 edges after `en` rises.
  - Only 0x63 has `m_last`=1; `byte_count`=4 at the end.
- Backpressure:
  - Same load, `m_ready`=0 for 6 cycles.
  - Exactly 2 reads are issued; `m_data` is held at 0x24; FIFO `full`=0 with 2 bytes left.
  - Then `m_ready`=1 → all 4 bytes arrive in order with no loss or duplicate.
- Empty / no-op:
  - FIFO empty, `en`=1, `m_ready`=1 for 5 cycles → `m_valid` stays 0 and `byte_count` is unchanged.
  - Then write 0x0d → 0x0d is delivered 2 edges after `fifo_empty` falls.
- Gating and reset mid-stream:
  - Drop `en` on the cycle a read is issued → that byte is still delivered and no further read is issued.
  - Assert `resetn`=0 with `occ`=2 → outputs clear immediately.
  - After release, `pkt_idx` restarts: the 4th byte has `m_last`=1.
- Wrap and stress:
  - `PKT_LEN`=3 with random `m_ready` over 1000 bytes through the FIFO from a random writer.
  - In-order data; `m_last` on every 3rd byte; `byte_count` equals bytes accepted modulo 2^16.
  - The TWO-plus-capture-without-pop assertion never fires.
